// File: rtl/sindoku_checker.sv
// SINdoku solution-check sequencer: streams rows, columns and (optionally) boxes from
// the board memory and reports the first empty, out-of-range or duplicate cell.
module sindoku_checker #(
  parameter bit CHECK_BOXES = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CEN,
  input  logic       Start,
  input  logic       Ack,
  output logic [6:0] rd_addr,
  output logic       rd_en,
  input  logic [3:0] cell_val,
  output logic       q_I,
  output logic       q_Check,
  output logic       q_Correct,
  output logic       q_Incorrect,
  output logic [1:0] err_kind,
  output logic [3:0] err_row,
  output logic [3:0] err_col
);

  typedef enum logic [3:0] {
    Q_I         = 4'b0001,
    Q_CHECK     = 4'b0010,
    Q_CORRECT   = 4'b0100,
    Q_INCORRECT = 4'b1000
  } state_t;

  localparam logic [4:0] LAST_G = CHECK_BOXES ? 5'd26 : 5'd17;

  state_t     r_state;
  logic [4:0] r_g;
  logic [3:0] r_e;
  logic       r_issue;
  logic [8:0] r_mask;
  logic       r_pv;
  logic       r_plast;
  logic [3:0] r_pe;
  logic [3:0] r_prow;
  logic [3:0] r_pcol;
  logic [1:0] r_err_kind;
  logic [3:0] r_err_row;
  logic [3:0] r_err_col;

  logic [3:0] w_row;
  logic [3:0] w_col;
  logic [3:0] w_b;
  logic [3:0] w_br;
  logic [3:0] w_bc;
  logic [3:0] w_er;
  logic [3:0] w_ec;
  logic       w_last;
  logic [8:0] w_mask_eff;
  logic [8:0] w_bit;
  logic [1:0] w_kind;

  // Map (group, element) onto a board cell for the issue stage.
  always_comb begin
    w_b  = 4'(r_g - 5'd18);
    w_br = w_b / 4'd3;
    w_bc = w_b % 4'd3;
    w_er = r_e / 4'd3;
    w_ec = r_e % 4'd3;
    if (r_g < 5'd9) begin
      w_row = r_g[3:0];
      w_col = r_e;
    end else if (r_g < 5'd18) begin
      w_row = r_e;
      w_col = 4'(r_g - 5'd9);
    end else begin
      w_row = w_br * 4'd3 + w_er;
      w_col = w_bc * 4'd3 + w_ec;
    end
  end

  assign w_last  = (r_g == LAST_G) && (r_e == 4'd8);
  assign rd_addr = {3'd0, w_row} * 7'd9 + {3'd0, w_col};
  assign rd_en   = CEN & r_issue & (r_state == Q_CHECK);

  // Classify the returned cell; the mask reads as empty at the start of each group.
  always_comb begin
    w_mask_eff = (r_pe == 4'd0) ? 9'd0 : r_mask;
    w_bit      = 9'd1 << (cell_val - 4'd1);
    if (cell_val == 4'd0) begin
      w_kind = 2'd1;
    end else if (cell_val > 4'd9) begin
      w_kind = 2'd3;
    end else if ((w_mask_eff & w_bit) != 9'd0) begin
      w_kind = 2'd2;
    end else begin
      w_kind = 2'd0;
    end
  end

  // Sequencer FSM with issue counters, one-deep read pipeline and error latch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= Q_I;
      r_g        <= 5'd0;
      r_e        <= 4'd0;
      r_issue    <= 1'b0;
      r_mask     <= 9'd0;
      r_pv       <= 1'b0;
      r_plast    <= 1'b0;
      r_pe       <= 4'd0;
      r_prow     <= 4'd0;
      r_pcol     <= 4'd0;
      r_err_kind <= 2'd0;
      r_err_row  <= 4'd0;
      r_err_col  <= 4'd0;
    end else if (CEN) begin
      case (r_state)
        Q_I: begin
          if (Start) begin
            r_state    <= Q_CHECK;
            r_g        <= 5'd0;
            r_e        <= 4'd0;
            r_issue    <= 1'b1;
            r_mask     <= 9'd0;
            r_pv       <= 1'b0;
            r_err_kind <= 2'd0;
            r_err_row  <= 4'd0;
            r_err_col  <= 4'd0;
          end
        end
        Q_CHECK: begin
          r_pv    <= r_issue;
          r_plast <= w_last;
          r_pe    <= r_e;
          r_prow  <= w_row;
          r_pcol  <= w_col;
          if (r_issue) begin
            if (r_e == 4'd8) begin
              r_e <= 4'd0;
              r_g <= r_g + 5'd1;
            end else begin
              r_e <= r_e + 4'd1;
            end
            if (w_last) r_issue <= 1'b0;
          end
          if (r_pv) begin
            if (w_kind != 2'd0) begin
              r_state    <= Q_INCORRECT;
              r_err_kind <= w_kind;
              r_err_row  <= r_prow;
              r_err_col  <= r_pcol;
              r_issue    <= 1'b0;
              r_pv       <= 1'b0;
            end else begin
              r_mask <= w_mask_eff | w_bit;
              if (r_plast) begin
                r_state <= Q_CORRECT;
                r_pv    <= 1'b0;
              end
            end
          end
        end
        Q_CORRECT, Q_INCORRECT: begin
          if (Ack) r_state <= Q_I;
        end
        default: r_state <= Q_I;
      endcase
    end
  end

  assign {q_Incorrect, q_Correct, q_Check, q_I} = r_state;
  assign err_kind = r_err_kind;
  assign err_row  = r_err_row;
  assign err_col  = r_err_col;

endmodule

// File: tb/tb_sindoku_checker.sv
// Bench for sindoku_checker: two instances (boxes on / off) share the stimulus; a
// group-walk model predicts the result and its timing, checked every cycle.
module tb_sindoku_checker;

  logic Clk;
  logic Reset;
  logic CEN;
  logic Start;
  logic Ack;

  wire  [1:0][6:0] rd_addr_w;
  wire  [1:0]      rd_en_w;
  wire  [1:0][3:0] q_w;
  wire  [1:0][1:0] kind_w;
  wire  [1:0][3:0] row_w;
  wire  [1:0][3:0] col_w;
  logic [1:0][3:0] cv_w;

  logic [3:0] board [0:80];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  int edge_ix = 0;
  int ng_of [2] = '{18, 27};
  int es [2];
  int k [2];
  int mt [2];
  int mst [2];
  int mk [2];
  int mr [2];
  int mc [2];
  int ek [2];
  int er [2];
  int ec [2];
  int res_edge [2];

  sindoku_checker #(.CHECK_BOXES(1'b0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
    .rd_addr(rd_addr_w[0]), .rd_en(rd_en_w[0]), .cell_val(cv_w[0]),
    .q_I(q_w[0][0]), .q_Check(q_w[0][1]), .q_Correct(q_w[0][2]), .q_Incorrect(q_w[0][3]),
    .err_kind(kind_w[0]), .err_row(row_w[0]), .err_col(col_w[0])
  );

  sindoku_checker #(.CHECK_BOXES(1'b1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
    .rd_addr(rd_addr_w[1]), .rd_en(rd_en_w[1]), .cell_val(cv_w[1]),
    .q_I(q_w[1][0]), .q_Check(q_w[1][1]), .q_Correct(q_w[1][2]), .q_Incorrect(q_w[1][3]),
    .err_kind(kind_w[1]), .err_row(row_w[1]), .err_col(col_w[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // synchronous-read board memory, one per instance
  always @(posedge Clk) begin
    for (int d = 0; d < 2; d++)
      if (rd_en_w[d] && rd_addr_w[d] < 7'd81) cv_w[d] <= board[rd_addr_w[d]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void cell_of(input int g, input int e, output int r, output int c);
    int b;
    b = g - 18;
    if (g < 9) begin r = g; c = e; end
    else if (g < 18) begin r = e; c = g - 9; end
    else begin r = (b / 3) * 3 + e / 3; c = (b % 3) * 3 + e % 3; end
  endfunction

  function automatic int addr_of(input int i);
    int r, c;
    cell_of(i / 9, i % 9, r, c);
    return r * 9 + c;
  endfunction

  // Walk every group in order; the first bad cell at index i surfaces at edge i+2.
  function automatic void model(input int ng, output int t, output int st,
                                output int kind, output int row, output int col);
    int seen [10];
    int r, c, v;
    t = ng * 9 + 1; st = 2; kind = 0; row = 0; col = 0;
    for (int i = 0; i < ng * 9; i++) begin
      if (i % 9 == 0) for (int j = 0; j < 10; j++) seen[j] = 0;
      cell_of(i / 9, i % 9, r, c);
      v = int'(board[r * 9 + c]);
      if (v == 0) kind = 1;
      else if (v > 9) kind = 3;
      else if (seen[v] != 0) kind = 2;
      else seen[v] = 1;
      if (kind != 0) begin
        t = i + 2; st = 3; row = r; col = c;
        return;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input int s);
    logic [3:0] v;
    v = 4'b0001 << s;
    return v;
  endfunction

  // per-cycle comparison of both instances against the tracked expectation
  always @(negedge Clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        logic exp_en;
        chk($sformatf("state_d%0d", d), 32'(q_w[d]), 32'(onehot(es[d])));
        chk($sformatf("err_d%0d", d), {22'd0, kind_w[d], row_w[d], col_w[d]},
            32'((ek[d] << 8) | (er[d] << 4) | ec[d]));
        exp_en = (es[d] == 1 && k[d] < ng_of[d] * 9) ? CEN : 1'b0;
        chk($sformatf("rd_en_d%0d", d), 32'(rd_en_w[d]), 32'(exp_en));
        if (es[d] == 1 && k[d] < ng_of[d] * 9)
          chk($sformatf("rd_addr_d%0d", d), 32'(rd_addr_w[d]), 32'(addr_of(k[d])));
      end
    end
  end

  task automatic step(input logic cen, input logic st, input logic ak);
    int e_now;
    @(negedge Clk); #1;
    CEN = cen; Start = st; Ack = ak;
    @(posedge Clk); #1;
    e_now = edge_ix;
    if (cen) begin
      for (int d = 0; d < 2; d++) begin
        case (es[d])
          0: if (st) begin
            es[d] = 1; k[d] = 0; ek[d] = 0; er[d] = 0; ec[d] = 0; e_now = 0;
            model(ng_of[d], mt[d], mst[d], mk[d], mr[d], mc[d]);
          end
          1: begin
            k[d] = k[d] + 1;
            if (k[d] == mt[d]) begin
              es[d] = mst[d]; ek[d] = mk[d]; er[d] = mr[d]; ec[d] = mc[d];
              res_edge[d] = e_now;
            end
          end
          default: if (ak) es[d] = 0;
        endcase
      end
    end
    edge_ix = e_now + 1;
  endtask

  task automatic async_reset();
    @(posedge Clk); #3;
    Reset = 1'b1; #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("arst_q_d%0d", d), 32'(q_w[d]), 32'h1);
      chk($sformatf("arst_err_d%0d", d), {22'd0, kind_w[d], row_w[d], col_w[d]}, 32'h0);
      es[d] = 0; k[d] = 0; ek[d] = 0; er[d] = 0; ec[d] = 0;
    end
    @(posedge Clk); #1;
    Reset = 1'b0; Start = 1'b0; Ack = 1'b0;
  endtask

  task automatic run_check(input int stall_at, input int stall_len, input int rst_at,
                           input logic ack_at_start);
    int guard;
    logic both;
    step(1'b1, 1'b1, ack_at_start);
    guard = 0;
    while (!(es[0] >= 2 && es[1] >= 2) && guard < 400) begin
      if (edge_ix == rst_at) begin
        async_reset();
        return;
      end
      both = (es[0] == 1 && es[1] == 1);
      step(!(edge_ix >= stall_at && edge_ix < stall_at + stall_len),
           both && edge_ix == 20, both && edge_ix == 30);
      guard = guard + 1;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic fill_valid();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r * 9 + c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endtask

  task automatic pin_result(input string nm, input int d, input int edge_exp,
                            input int kind, input int row, input int col);
    chk({nm, "_edge"}, 32'(res_edge[d]), 32'(edge_exp));
    chk({nm, "_err"}, {22'd0, kind_w[d], row_w[d], col_w[d]},
        32'((kind << 8) | (row << 4) | col));
  endtask

  initial begin
    Reset = 1'b1; CEN = 1'b1; Start = 1'b0; Ack = 1'b0;
    for (int d = 0; d < 2; d++) begin
      es[d] = 0; k[d] = 0; ek[d] = 0; er[d] = 0; ec[d] = 0; res_edge[d] = -1;
    end
    fill_valid();
    repeat (3) @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_q_d%0d", d), 32'(q_w[d]), 32'h1);
      chk($sformatf("reset_en_d%0d", d), 32'(rd_en_w[d]), 32'h0);
      chk($sformatf("reset_addr_d%0d", d), 32'(rd_addr_w[d]), 32'h0);
      chk($sformatf("reset_err_d%0d", d), {22'd0, kind_w[d], row_w[d], col_w[d]}, 32'h0);
    end
    @(negedge Clk); #1;
    Reset = 1'b0;
    chk_on = 1'b1;

    // solved board; stray Start at edge 20 and Ack at edge 30 during the check
    run_check(-1, 0, -1, 1'b0);
    pin_result("valid_b1", 1, 244, 0, 0, 0);
    pin_result("valid_b0", 0, 163, 0, 0, 0);

    fill_valid(); board[4 * 9 + 5] = 4'd0;
    run_check(-1, 0, -1, 1'b0);
    pin_result("empty_b1", 1, 43, 1, 4, 5);
    pin_result("empty_b0", 0, 43, 1, 4, 5);

    fill_valid(); board[8] = board[0];
    run_check(-1, 0, -1, 1'b0);
    pin_result("dup_b1", 1, 10, 2, 0, 8);

    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r * 9 + c] = 4'(((r + c) % 9) + 1);
    run_check(-1, 0, -1, 1'b0);
    pin_result("latin_b1", 1, 167, 2, 1, 0);
    pin_result("latin_b0", 0, 163, 0, 0, 0);

    fill_valid();
    run_check(50, 10, -1, 1'b0);
    pin_result("stall_b1", 1, 254, 0, 0, 0);
    pin_result("stall_b0", 0, 173, 0, 0, 0);

    // out-of-range cell; Start arrives together with Ack and must win
    fill_valid(); board[2 * 9 + 2] = 4'd12;
    run_check(-1, 0, -1, 1'b1);
    pin_result("range_b1", 1, 22, 3, 2, 2);

    // error fields survive into Q_I, then an async reset clears them
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("held_err_b1", {22'd0, kind_w[1], row_w[1], col_w[1]}, 32'h322);
    async_reset();

    fill_valid();
    run_check(-1, 0, 100, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
